// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_if
//  Purpose  : Instruction-memory request/response bus between fetch unit and
//             instruction memory (one request outstanding at a time).
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Non-prefetching instruction fetch unit: holds the PC, issues one
//             memory request at a time, presents decoded instruction fields.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    instr_fetch_if.master    imem,
    input  wire logic        PCSrc,
    input  wire logic [31:0] ImmExt,
    input  wire logic        stall,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic             misaligned,
    output logic [31:0]      instr_count
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_count;
    logic        r_misaligned;
    logic [31:0] w_next_pc;

    // Only consulted on a consume in VALID; carry out of bit 31 is discarded.
    assign w_next_pc = PCSrc ? (r_pc + ImmExt) : (r_pc + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ISSUE;
            r_pc         <= RESET_PC;
            r_instr      <= c_NOP;
            r_count      <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_valid) begin
                        r_instr <= imem.imem_rdata;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        r_count <= r_count + 32'd1;
                        if (w_next_pc[1:0] == 2'b00) begin
                            r_pc    <= w_next_pc;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_misaligned <= 1'b1;
                            r_state      <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    // Strobes are pure state decodes so no input reaches an output combinationally.
    assign imem.imem_req  = (r_state == ST_ISSUE);
    assign imem.imem_addr = r_pc;
    assign instr_valid    = (r_state == ST_VALID);

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign misaligned  = r_misaligned;
    assign instr_count = r_count;

    assign opcode = r_instr[6:0];
    assign rd     = r_instr[11:7];
    assign funct3 = r_instr[14:12];
    assign rs1    = r_instr[19:15];
    assign rs2    = r_instr[24:20];
    assign funct7 = r_instr[31:25];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch with a behavioural memory
//             and PC/counter reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmExt = 32'd0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        instr_valid;
    logic [31:0] pc;
    logic        misaligned;
    logic [31:0] instr_count;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .stall       (stall),
        .instr       (instr),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .instr_valid (instr_valid),
        .pc          (pc),
        .misaligned  (misaligned),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
    logic        exp_mis;
    logic        exp_fault;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = $urandom;
        return mem[addr];
    endfunction

    task automatic model_reset();
        exp_pc    = c_RESET_PC;
        exp_instr = c_NOP;
        exp_count = 32'd0;
        exp_mis   = 1'b0;
        exp_fault = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"},    pc,          c_RESET_PC);
        chk({tag, "_instr"}, instr,       c_NOP);
        chk({tag, "_valid"}, instr_valid, 1'b0);
        chk({tag, "_mis"},   misaligned,  1'b0);
        chk({tag, "_count"}, instr_count, 32'd0);
        chk({tag, "_req"},   bus.imem_req, 1'b1);
    endtask

    task automatic check_fields();
        chk("opcode", opcode, exp_instr[6:0]);
        chk("rd",     rd,     exp_instr[11:7]);
        chk("funct3", funct3, exp_instr[14:12]);
        chk("rs1",    rs1,    exp_instr[19:15]);
        chk("rs2",    rs2,    exp_instr[24:20]);
        chk("funct7", funct7, exp_instr[31:25]);
    endtask

    // Entered at a falling edge while the DUT is issuing; leaves at the falling
    // edge after the consume (next ISSUE, or FAULT).
    task automatic do_fetch(input int k, input int nstall, input bit spur,
                            input bit pcsrc, input logic [31:0] imm, input bit stray);
        logic [31:0] word;
        logic [31:0] nxt;
        word = memword(exp_pc);
        chk("issue_req",   bus.imem_req,  1'b1);
        chk("issue_addr",  bus.imem_addr, exp_pc);
        chk("issue_valid", instr_valid,   1'b0);
        if (stray) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = ~word;
        end
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            chk("wait_req",   bus.imem_req, 1'b0);
            chk("wait_valid", instr_valid,  1'b0);
            chk("wait_instr", instr,        exp_instr);
            bus.imem_valid = (i == k);
            bus.imem_rdata = (i == k) ? word : $urandom;
        end
        @(negedge clk);
        bus.imem_valid = 1'b0;
        exp_instr = word;
        chk("valid",       instr_valid,  1'b1);
        chk("valid_req",   bus.imem_req, 1'b0);
        chk("valid_instr", instr,        exp_instr);
        chk("valid_pc",    pc,           exp_pc);
        check_fields();
        for (int s = 0; s < nstall; s++) begin
            stall  = 1'b1;
            PCSrc  = 1'($urandom);
            ImmExt = $urandom;
            if (spur) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = $urandom;
            end
            @(negedge clk);
            bus.imem_valid = 1'b0;
            chk("stall_valid", instr_valid,  1'b1);
            chk("stall_req",   bus.imem_req, 1'b0);
            chk("stall_instr", instr,        exp_instr);
            chk("stall_pc",    pc,           exp_pc);
            chk("stall_count", instr_count,  exp_count);
        end
        stall  = 1'b0;
        PCSrc  = pcsrc;
        ImmExt = imm;
        @(negedge clk);
        nxt = pcsrc ? exp_pc + imm : exp_pc + 32'd4;
        exp_count = exp_count + 1;
        if (nxt % 4 != 0) begin
            exp_mis   = 1'b1;
            exp_fault = 1'b1;
        end else begin
            exp_pc = nxt;
        end
        PCSrc  = 1'($urandom);
        ImmExt = $urandom;
        chk("cons_count", instr_count,  exp_count);
        chk("cons_mis",   misaligned,   exp_mis);
        chk("cons_pc",    pc,           exp_pc);
        chk("cons_addr",  bus.imem_addr, exp_pc);
        chk("cons_req",   bus.imem_req, !exp_fault);
        chk("cons_valid", instr_valid,  1'b0);
    endtask

    task automatic jump_to(input logic [31:0] target);
        do_fetch(1, 0, 1'b0, 1'b1, target - exp_pc, 1'b0);
    endtask

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'd0;
        model_reset();
        mem[32'h0000_0000] = 32'h0050_0093;

        // Reset state
        @(negedge clk);
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // First instruction: addi x1, x0, 5
        do_fetch(1, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("first_opcode", {25'd0, opcode}, 32'h13);
        chk("first_rd",     {27'd0, rd},     32'd1);
        chk("first_funct3", {29'd0, funct3}, 32'd0);
        chk("first_rs1",    {27'd0, rs1},    32'd0);
        chk("first_addr",   bus.imem_addr,   32'd4);
        chk("first_count",  instr_count,     32'd1);

        // Sequential run up to 8 instructions
        for (int n = 0; n < 7; n++) do_fetch(1, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("seq_count", instr_count, 32'd8);
        chk("seq_pc",    pc,          32'h20);

        // Branch cases around PC 0x10
        jump_to(32'h10);
        do_fetch(1, 0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        chk("bne_taken", bus.imem_addr, 32'h08);
        do_fetch(1, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        do_fetch(1, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        do_fetch(1, 0, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0);
        chk("bne_not_taken", bus.imem_addr, 32'h14);

        // Randomized latency, stalls, spurious responses, aligned branches
        for (int n = 0; n < 30; n++) begin
            int off;
            off = ($urandom_range(0, 64) - 32) * 4;
            do_fetch($urandom_range(1, 4), $urandom_range(0, 5), 1'($urandom),
                     1'($urandom), 32'(off), 1'b0);
        end
        do_fetch(3, 5, 1'b1, 1'b0, 32'd0, 1'b0);

        // PC wrap from the top of the address space
        jump_to(32'hFFFF_FFFC);
        do_fetch(2, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Misaligned branch target enters FAULT
        jump_to(32'h20);
        do_fetch(1, 1, 1'b0, 1'b1, 32'd2, 1'b0);
        for (int s = 0; s < 4; s++) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = $urandom;
            stall = 1'($urandom);
            @(negedge clk);
            bus.imem_valid = 1'b0;
            chk("fault_req",   bus.imem_req, 1'b0);
            chk("fault_valid", instr_valid,  1'b0);
            chk("fault_mis",   misaligned,   1'b1);
            chk("fault_pc",    pc,           32'h20);
            chk("fault_instr", instr,        exp_instr);
            chk("fault_count", instr_count,  exp_count);
        end
        stall = 1'b0;

        // Reset pulse leaves FAULT
        rst_n = 1'b0;
        #1;
        check_reset_values("fault_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 3; n++) do_fetch($urandom_range(1, 3), 0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of WAIT
        chk("pre_async_count", instr_count, 32'd3);
        @(negedge clk);
        chk("async_in_wait", bus.imem_req, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_fetch(2, 0, 1'b0, 1'b0, 32'd0, 1'b1);
        do_fetch(1, 2, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("final_count", instr_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
